uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Arbiter and sequencer that shares the single UART transmitter between two byte sources: the MIPS memory-mapped UART write port (requester 0) and the RX-echo/debug path (requester 1). It accepts one byte at a time through valid/ready handshakes and issues a one-cycle start pulse to the transmitter. It tracks the transmitter's busy flag to frame each transfer and flags a transmitter that never starts. It sits between `mips_system` bus logic and the baud-driven TX shifter.

## Interface
- `TIMEOUT`, 16: cycles to wait for `tx_busy` to rise after `tx_start` before declaring a fault; legal range 2..255.
- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has a byte.
- `req0_data` in 8: requester 0 byte.
- `req0_ready` out 1: requester 0 byte accepted this cycle.
- `req1_valid` in 1: requester 1 has a byte.
- `req1_data` in 8: requester 1 byte.
- `req1_ready` out 1: requester 1 byte accepted this cycle.
- `tx_data` out 8: byte presented to the transmitter; registered.
- `tx_start` out 1: one-cycle start pulse to the transmitter; registered.
- `tx_busy` in 1: transmitter frame in progress.
- `grant` out 2: one-hot owner of the current transfer; 00 when idle.
- `err` out 1: sticky timeout flag.
- `err_clr` in 1: clears `err`.

## Operation
- Reset values: state IDLE, `tx_data`=0x00, `tx_start`=0, `grant`=00, `err`=0, timeout counter 0. The last-served pointer resets to 1, so requester 0 wins the first tie.
- **IDLE**
  - Winner = the only valid requester. If both are valid, the winner is decided per Configuration.
  - `reqN_ready` = 1 for the winner only, combinationally from `reqN_valid` and state.
  - On handshake: latch `reqN_data` into `tx_data`, set `grant` one-hot to N, go to START.
- **START**
  - `tx_start`=1 for exactly this cycle, then go to WAIT_BUSY with the counter cleared.
- **WAIT_BUSY**
  - If `tx_busy`=1, go to WAIT_IDLE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`-1 with `tx_busy` still low: set `err`=1, clear `grant`, go to IDLE. The last-served pointer still updates to N.
- **WAIT_IDLE**
  - Wait for `tx_busy`=0. Then clear `grant`, set last-served to N, go to IDLE.
- Ready is never asserted outside IDLE. `tx_data` holds its value from the handshake until the next handshake.
- `err_clr` clears `err`. If `err_clr` coincides with a timeout, set wins and `err`=1.
- The counter is 8 bits and saturates. It never wraps.
- Reset mid-transfer returns to IDLE immediately and drops `tx_start` and `grant`. A frame already inside the transmitter is not aborted by this block.

## Timing
- Handshake at cycle N → `tx_start` high in cycle N+1 → earliest `tx_busy` sample in N+2.
- `tx_busy` sampled low in WAIT_IDLE at cycle M → IDLE at M+1, where the next handshake may occur → next `tx_start` at M+2.
- Minimum spacing between `tx_start` pulses = frame length + 3 cycles.
- Timeout fires `TIMEOUT` cycles after entering WAIT_BUSY. `err` is visible the following cycle.
- Only `reqN_ready` is combinational, and it depends on `reqN_valid` and state only. All other outputs are registered.

## Configuration
- `UART_ARB_RR_EN` defined: round-robin. On a tie, the requester not last served wins, so both sources alternate under continuous load.
- `UART_ARB_RR_EN` undefined: fixed priority. Requester 0 always wins ties. The last-served pointer is still maintained but is unused.

## Test plan
- Single byte: `req0_valid` with 0x55, transmitter model raises busy 2 cycles after start for 10 cycles.
  - Required: `req0_ready` for 1 cycle; `tx_start` 1 cycle later with `tx_data`=0x55; `grant`=01 until busy falls; then `grant`=00.
- Simultaneous requests: req0=0xA1 and req1=0xB2 both held valid for 4 transfers, with `UART_ARB_RR_EN` defined.
  - Required: byte order 0xA1, 0xB2, 0xA1, 0xB2.
- Same stimulus with `UART_ARB_RR_EN` undefined.
  - Required: 0xA1 sent 4 times; `req1_ready` never asserted.
- Dead transmitter: `tx_busy` tied 0, `TIMEOUT`=16, req1 sends 0x3C.
  - Required: `err`=1 exactly 16 cycles after WAIT_BUSY entry; `grant`=00.
  - Then: `err_clr` pulse → `err`=0. `err_clr` asserted on the timeout cycle → `err`=1.
- Reset during WAIT_IDLE with `tx_busy` high: deassert `rst` for 1 cycle.
  - Required: `grant`=00, `tx_start`=0, `tx_data`=0x00.
  - After busy falls: a new req0 byte 0x7E is accepted on the first IDLE cycle.
- Back-to-back: req0 streams 0x01..0x04.
  - Required: `tx_start` pulses spaced by frame length + 3 cycles; no byte dropped or duplicated.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between two byte sources.
// Optional round-robin tie-break enabled by defining UART_ARB_RR_EN.
module uart_tx_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   output logic [1:0] grant,
   output logic       err,
   input  logic       err_clr
);

`ifdef UART_ARB_RR_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_WAIT_IDLE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_start_q, tx_start_d;
   logic [1:0] grant_q, grant_d;
   logic       err_q, err_d;
   logic [7:0] cnt_q, cnt_d;
   logic       last_q, last_d;

   logic       idle;
   logic       tie_pick1;
   logic       pick0;
   logic       pick1;

   assign idle      = (state_q == S_IDLE);
   // tie goes to requester 1 only when round-robin and 0 was served last
   assign tie_pick1 = RR_EN & ~last_q;
   assign pick1     = req1_valid & (~req0_valid | tie_pick1);
   assign pick0     = req0_valid & ~pick1;

   assign req0_ready = idle & pick0;
   assign req1_ready = idle & pick1;

   assign tx_data  = tx_data_q;
   assign tx_start = tx_start_q;
   assign grant    = grant_q;
   assign err      = err_q;

   // next-state, transfer framing and timeout detection
   always_comb begin
      state_d    = state_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      grant_d    = grant_q;
      err_d      = err_q & ~err_clr;
      cnt_d      = cnt_q;
      last_d     = last_q;
      unique case (state_q)
         S_IDLE: begin
            if (req0_ready | req1_ready) begin
               tx_data_d  = req1_ready ? req1_data : req0_data;
               grant_d    = {req1_ready, req0_ready};
               tx_start_d = 1'b1;
               state_d    = S_START;
            end
         end
         S_START: begin
            cnt_d   = 8'd0;
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = S_WAIT_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               grant_d = 2'b00;
               last_d  = grant_q[1];
               state_d = S_IDLE;
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WAIT_IDLE: begin
            if (!tx_busy) begin
               grant_d = 2'b00;
               last_d  = grant_q[1];
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         tx_data_q  <= 8'h00;
         tx_start_q <= 1'b0;
         grant_q    <= 2'b00;
         err_q      <= 1'b0;
         cnt_q      <= 8'd0;
         last_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         grant_q    <= grant_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a transfer-level model and
// a transmitter model that raises busy a set delay after each start.
module tb_uart_tx_arbiter;

   localparam int TIMEOUT = 16;
   localparam int LOGN = 4096;
`ifdef UART_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_data, req1_data;
   logic       req0_ready, req1_ready;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic [1:0] grant;
   logic       err;
   logic       err_clr;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data),
      .req1_ready(req1_ready),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .grant(grant), .err(err), .err_clr(err_clr)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // transmitter model
   bit tx_dead = 1'b0;
   int tx_delay = 2;
   int tx_len = 10;
   int rise_at = -100;
   int fall_at = -100;
   always @(negedge clk)
      if (tx_start === 1'b1 && !tx_dead) begin
         rise_at = cyc + tx_delay;
         fall_at = cyc + tx_delay + tx_len;
      end
   always begin
      @(posedge clk);
      #1;
      tx_busy = (cyc >= rise_at && cyc < fall_at);
   end

   // transfer-level model
   int         m_owner = -1;
   int         m_age = 0;
   bit         m_seen = 1'b0;
   bit         m_last = 1'b1;
   logic [7:0] m_data = 8'h00;
   bit         m_err = 1'b0;

   function automatic logic [1:0] exp_ready(logic v0, logic v1);
      if (m_owner != -1) return 2'b00;
      if (v0 && v1) return (RR && !m_last) ? 2'b10 : 2'b01;
      return {v1, v0};
   endfunction

   always @(posedge clk or negedge rst) begin : model
      int o, a;
      bit s, l, e, to;
      logic [7:0] d;
      logic [1:0] r;
      if (!rst) begin
         m_owner <= -1; m_age <= 0; m_seen <= 1'b0;
         m_last <= 1'b1; m_data <= 8'h00; m_err <= 1'b0;
      end else begin
         o = m_owner; a = m_age; s = m_seen;
         l = m_last; d = m_data; e = m_err; to = 1'b0;
         r = exp_ready(req0_valid, req1_valid);
         if (o == -1) begin
            if (r != 2'b00) begin
               o = r[1] ? 1 : 0;
               d = r[1] ? req1_data : req0_data;
               a = 0; s = 1'b0;
            end
         end else if (a == 0) begin
            a = 1;
         end else if (!s) begin
            if (tx_busy) s = 1'b1;
            else if (a == TIMEOUT) begin
               to = 1'b1; l = o[0]; o = -1;
            end else a = a + 1;
         end else if (!tx_busy) begin
            l = o[0]; o = -1;
         end
         if (err_clr) e = 1'b0;
         if (to) e = 1'b1;
         m_owner <= o; m_age <= a; m_seen <= s;
         m_last <= l; m_data <= d; m_err <= e;
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin : cmp
      logic [1:0] er;
      er = exp_ready(req0_valid, req1_valid);
      chk("req0_ready", req0_ready, er[0]);
      chk("req1_ready", req1_ready, er[1]);
      chk("tx_start", tx_start, (m_owner != -1 && m_age == 0));
      chk("tx_data", tx_data, m_data);
      chk("grant", grant,
          m_owner == -1 ? 0 : (m_owner == 1 ? 2 : 1));
      chk("err", err, m_err);
   end

   // cycle log for literal timing checks
   logic [1:0] log_grant [LOGN];
   logic       log_err   [LOGN];
   logic       log_r0    [LOGN];
   logic       log_r1    [LOGN];
   logic [7:0] sent_b [$];
   int         sent_c [$];
   always @(negedge clk) begin
      if (cyc < LOGN) begin
         log_grant[cyc] = grant;
         log_err[cyc] = err;
         log_r0[cyc] = req0_ready;
         log_r1[cyc] = req1_ready;
      end
      if (tx_start === 1'b1) begin
         sent_b.push_back(tx_data);
         sent_c.push_back(cyc);
      end
   end

   task automatic tick(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_cyc(int c);
      for (int g = 0; g < 5000 && cyc < c; g++) tick(1);
   endtask

   task automatic send(int who, logic [7:0] d, output int hs);
      hs = -1;
      if (who == 0) begin req0_valid = 1; req0_data = d; end
      else begin req1_valid = 1; req1_data = d; end
      for (int g = 0; g < 300; g++) begin
         @(negedge clk);
         if ((who == 0 ? req0_ready : req1_ready) === 1'b1) hs = cyc;
         @(posedge clk);
         #1;
         if (hs >= 0) break;
      end
      if (who == 0) req0_valid = 0;
      else req1_valid = 0;
      checks++;
      if (hs < 0) begin
         errors++;
         $display("FAIL send_handshake: got none expected ready");
      end
   endtask

   initial begin
      int hs, s, w, n0, c0, cnt;
      logic [7:0] eb;
      rst = 1'b0;
      req0_valid = 0; req1_valid = 0;
      req0_data = 0; req1_data = 0;
      err_clr = 0; tx_busy = 0;
      tick(3);
      rst = 1'b1;
      tick(2);
      chk("rst_grant", grant, 2'b00);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_tx_start", tx_start, 1'b0);
      chk("rst_err", err, 1'b0);

      // single byte
      tx_delay = 2; tx_len = 10;
      n0 = sent_b.size();
      send(0, 8'h55, hs);
      s = hs + 1;
      wait_cyc(s + 20);
      chk("t1_count", sent_b.size(), n0 + 1);
      chk("t1_byte", sent_b[n0], 8'h55);
      chk("t1_start_cyc", sent_c[n0], hs + 1);
      chk("t1_grant_s", log_grant[s], 2'b01);
      chk("t1_grant_last", log_grant[s + 12], 2'b01);
      chk("t1_grant_off", log_grant[s + 13], 2'b00);
      cnt = 0;
      for (int c = hs - 2; c < s + 20; c++) cnt += int'(log_r0[c]);
      chk("t1_ready_cycles", cnt, 1);

      // simultaneous requests from a fresh reset
      rst = 1'b0; tick(1); rst = 1'b1; tick(1);
      tx_delay = 1; tx_len = 4;
      n0 = sent_b.size();
      c0 = cyc;
      req0_valid = 1; req0_data = 8'hA1;
      req1_valid = 1; req1_data = 8'hB2;
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            if ((req0_ready | req1_ready) === 1'b1) break;
            @(posedge clk);
            #1;
         end
         @(posedge clk);
         #1;
      end
      req0_valid = 0; req1_valid = 0;
      wait_cyc(cyc + 20);
      chk("t2_count", sent_b.size(), n0 + 4);
      for (int k = 0; k < 4; k++) begin
         eb = (RR && k % 2 == 1) ? 8'hB2 : 8'hA1;
         chk("t2_byte", sent_b[n0 + k], eb);
      end
      cnt = 0;
      for (int c = c0; c < cyc; c++) cnt += int'(log_r1[c]);
      chk("t2_req1_ready", cnt, RR ? 2 : 0);

      // dead transmitter
      tx_dead = 1'b1;
      send(1, 8'h3C, hs);
      w = hs + 2;
      wait_cyc(w + 18);
      chk("t3_byte", sent_b[sent_b.size() - 1], 8'h3C);
      chk("t3_err_before", log_err[w + 15], 1'b0);
      chk("t3_err_at", log_err[w + 16], 1'b1);
      chk("t3_grant_wait", log_grant[w + 15], 2'b10);
      chk("t3_grant_after", log_grant[w + 16], 2'b00);
      err_clr = 1; tick(1); err_clr = 0;
      chk("t3_err_clr", err, 1'b0);
      send(1, 8'h3C, hs);
      w = hs + 2;
      wait_cyc(w + 15);
      err_clr = 1; tick(1); err_clr = 0;
      wait_cyc(w + 18);
      chk("t3_coinc_before", log_err[w + 15], 1'b0);
      chk("t3_coinc_set_wins", log_err[w + 16], 1'b1);
      err_clr = 1; tick(1); err_clr = 0;
      tx_dead = 1'b0;

      // reset while waiting for the frame to end
      tx_delay = 1; tx_len = 20;
      send(0, 8'h11, hs);
      s = hs + 1;
      wait_cyc(s + 5);
      rst = 1'b0;
      @(negedge clk);
      chk("t4_grant", grant, 2'b00);
      chk("t4_tx_start", tx_start, 1'b0);
      chk("t4_tx_data", tx_data, 8'h00);
      chk("t4_busy_held", tx_busy, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int g = 0; g < 100 && tx_busy; g++) tick(1);
      chk("t4_busy_fell", tx_busy, 1'b0);
      req0_valid = 1; req0_data = 8'h7E;
      @(negedge clk);
      chk("t4_first_ready", req0_ready, 1'b1);
      @(posedge clk);
      #1;
      req0_valid = 0;
      chk("t4_data", tx_data, 8'h7E);
      chk("t4_start", tx_start, 1'b1);
      wait_cyc(cyc + 30);

      // back-to-back stream
      tx_delay = 1; tx_len = 6;
      n0 = sent_b.size();
      for (int i = 1; i <= 4; i++) send(0, 8'(i), hs);
      wait_cyc(cyc + 20);
      chk("t5_count", sent_b.size(), n0 + 4);
      for (int i = 0; i < 4; i++)
         chk("t5_byte", sent_b[n0 + i], i + 1);
      for (int i = 1; i < 4; i++)
         chk("t5_spacing", sent_c[n0 + i] - sent_c[n0 + i - 1], 9);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
